// File: rtl/clk_meas_pkg.sv
// Shared types and constants for the clock period meter: FSM states,
// default sizing and the period-field width helper.
package clk_meas_pkg;

  localparam int DEF_MAX_PERIOD = 64;
  localparam int DEF_AVG_LOG2   = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_MEASURE,
    ST_DONE
  } meas_state_t;

  // Bits needed to hold any period from 0 up to and including max_period.
  function automatic int period_width(input int max_period);
    return $clog2(max_period + 1);
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer for an asynchronous level plus a one-cycle pulse on
// each synchronized rising edge.
module sync_edge_detect (
  input  logic iclk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise
);

  logic r_meta;
  logic r_sync;
  logic r_dly;

  always_ff @(posedge iclk or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_dly  <= 1'b0;
    end else begin
      r_meta <= din;
      r_sync <= r_meta;
      r_dly  <= r_sync;
    end
  end

  assign dout = r_sync;
  assign rise = r_sync & ~r_dly;

endmodule

// File: rtl/clk_period_meter.sv
// Measures the rise-to-rise period of mclk in iclk cycles, averaged over
// 2^AVG_LOG2 periods, and reports it against an expected value.
module clk_period_meter
  import clk_meas_pkg::*;
#(
  parameter int MAX_PERIOD = DEF_MAX_PERIOD,
  parameter int AVG_LOG2   = DEF_AVG_LOG2,
  parameter int PW         = period_width(MAX_PERIOD)
) (
  input  logic          iclk,
  input  logic          rst,
  input  logic          mclk,
  input  logic          start,
  input  logic [PW-1:0] expected,
  output logic          busy,
  output logic          valid,
  input  logic          ready,
  output logic [PW-1:0] period,
  output logic          timeout,
  output logic          mismatch
);

  localparam int AW = PW + AVG_LOG2;
  localparam int NW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [PW-1:0] CNT_MAX    = PW'(MAX_PERIOD);
  localparam logic [NW-1:0] NSAMP_LAST = NW'((1 << AVG_LOG2) - 1);

  meas_state_t   r_state;
  logic [PW-1:0] r_cnt;
  logic [AW-1:0] r_acc;
  logic [NW-1:0] r_nsamp;
  logic [PW-1:0] r_expected;
  logic          r_busy;
  logic          r_valid;
  logic [PW-1:0] r_period;
  logic          r_timeout;
  logic          r_mismatch;

  logic          w_edge;
  logic          w_mclk_sync_unused;
  logic [AW-1:0] w_acc_sum;
  logic [PW-1:0] w_avg;

  sync_edge_detect u_sync (
    .iclk (iclk),
    .rst  (rst),
    .din  (mclk),
    .dout (w_mclk_sync_unused),
    .rise (w_edge)
  );

  // Sum including the sample that ends on this cycle's edge; the average is
  // the upper PW bits, which cannot exceed MAX_PERIOD.
  assign w_acc_sum = r_acc + AW'(r_cnt);
  assign w_avg     = w_acc_sum[AVG_LOG2 +: PW];

  always_ff @(posedge iclk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_acc      <= '0;
      r_nsamp    <= '0;
      r_expected <= '0;
      r_busy     <= 1'b0;
      r_valid    <= 1'b0;
      r_period   <= '0;
      r_timeout  <= 1'b0;
      r_mismatch <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_expected <= expected;
            r_acc      <= '0;
            r_nsamp    <= '0;
            r_cnt      <= PW'(1);
            r_busy     <= 1'b1;
            r_state    <= ST_ARM;
          end
        end
        ST_ARM: begin
          if (w_edge) begin
            r_cnt   <= PW'(1);
            r_state <= ST_MEASURE;
          end else if (r_cnt == CNT_MAX) begin
            r_valid    <= 1'b1;
            r_period   <= '0;
            r_timeout  <= 1'b1;
            r_mismatch <= 1'b1;
            r_state    <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + PW'(1);
          end
        end
        ST_MEASURE: begin
          if (w_edge) begin
            r_acc   <= w_acc_sum;
            r_cnt   <= PW'(1);
            r_nsamp <= r_nsamp + NW'(1);
            if (r_nsamp == NSAMP_LAST) begin
              r_valid    <= 1'b1;
              r_period   <= w_avg;
              r_timeout  <= 1'b0;
              r_mismatch <= (w_avg != r_expected);
              r_state    <= ST_DONE;
            end
          end else if (r_cnt == CNT_MAX) begin
            r_valid    <= 1'b1;
            r_period   <= '0;
            r_timeout  <= 1'b1;
            r_mismatch <= 1'b1;
            r_state    <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + PW'(1);
          end
        end
        ST_DONE: begin
          // Result held until the consumer takes it; start is not looked at here.
          if (r_valid && ready) begin
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
            r_period   <= '0;
            r_timeout  <= 1'b0;
            r_mismatch <= 1'b0;
            r_state    <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy     = r_busy;
  assign valid    = r_valid;
  assign period   = r_period;
  assign timeout  = r_timeout;
  assign mismatch = r_mismatch;

endmodule

// File: tb/tb_clk_period_meter.sv
// Directed bench for clk_period_meter: bench-generated divided clocks, a queue
// of expected results pushed at start and popped when valid appears.
module tb_clk_period_meter;

  localparam int PW = 7;

  logic          iclk = 1'b0;
  logic          rst  = 1'b1;
  logic          mclk = 1'b0;
  logic          start = 1'b0;
  logic [PW-1:0] expected_in = '0;
  logic          busy;
  logic          valid;
  logic          ready = 1'b0;
  logic [PW-1:0] period;
  logic          timeout;
  logic          mismatch;

  typedef struct {
    logic [PW-1:0] period;
    logic          timeout;
    logic          mismatch;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   mclk_div = 0;
  int   div_k = 0;

  clk_period_meter #(.MAX_PERIOD(64), .AVG_LOG2(2)) dut (
    .iclk     (iclk),
    .rst      (rst),
    .mclk     (mclk),
    .start    (start),
    .expected (expected_in),
    .busy     (busy),
    .valid    (valid),
    .ready    (ready),
    .period   (period),
    .timeout  (timeout),
    .mismatch (mismatch)
  );

  always #5 iclk = ~iclk;

  // Divided clock: one rising edge every mclk_div iclk cycles; 0 holds it low.
  always @(negedge iclk) begin
    if (mclk_div == 0) begin
      div_k = 0;
      mclk  = 1'b0;
    end else begin
      if (div_k >= mclk_div - 1) div_k = 0;
      else div_k = div_k + 1;
      mclk = (div_k < mclk_div / 2);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic run_meas(input int d, input int exp_p, input int hold,
                          input bit mid_start, input bit hs_start);
    exp_t e;
    exp_t got;
    int   n;
    mclk_div = d;
    repeat (20) @(negedge iclk);
    expected_in = PW'(exp_p);
    start = 1'b1;
    e.timeout  = (d == 0);
    e.period   = e.timeout ? '0 : PW'(d);
    e.mismatch = e.timeout || (d != exp_p);
    sb.push_back(e);
    @(posedge iclk);
    #1;
    start = 1'b0;
    expected_in = PW'(7'h55);
    chk("busy_after_start", busy, 1);
    n = 0;
    while (!valid && n < 400) begin
      if (mid_start && n == 12) begin
        start = 1'b1;
        expected_in = PW'(d + 1);
      end else begin
        start = 1'b0;
      end
      @(posedge iclk);
      #1;
      n++;
    end
    start = 1'b0;
    chk("valid_seen", valid, 1);
    if (d == 0) chk("timeout_latency", n, 64);
    got = sb.pop_front();
    $display("txn d=%0d exp=%0d -> period=%0d timeout=%0d mismatch=%0d after %0d cycles",
             d, exp_p, period, timeout, mismatch, n);
    chk("period", period, got.period);
    chk("timeout", timeout, got.timeout);
    chk("mismatch", mismatch, got.mismatch);
    for (int i = 0; i < hold; i++) begin
      @(posedge iclk);
      #1;
      chk("hold_stable", {valid, busy, timeout, mismatch, period},
          {1'b1, 1'b1, got.timeout, got.mismatch, got.period});
    end
    @(negedge iclk);
    ready = 1'b1;
    start = hs_start;
    expected_in = PW'(d + 2);
    @(posedge iclk);
    #1;
    ready = 1'b0;
    start = 1'b0;
    chk("valid_after_hs", valid, 0);
    chk("busy_after_hs", busy, 0);
    @(posedge iclk);
    #1;
    chk("busy_stays_idle", busy, 0);
  endtask

  initial begin
    repeat (3) @(negedge iclk);
    chk("rst_outputs", {busy, valid, timeout, mismatch, period}, 0);
    rst = 1'b0;

    run_meas(4, 4, 0, 1'b0, 1'b0);
    run_meas(3, 3, 20, 1'b0, 1'b0);
    run_meas(3, 5, 0, 1'b0, 1'b0);
    run_meas(0, 64, 0, 1'b0, 1'b0);
    run_meas(4, 4, 3, 1'b1, 1'b1);

    // Abort a D=6 run mid-measurement with an asynchronous reset.
    mclk_div = 6;
    repeat (20) @(negedge iclk);
    expected_in = PW'(9);
    start = 1'b1;
    @(posedge iclk);
    #1;
    start = 1'b0;
    repeat (15) @(posedge iclk);
    #2;
    chk("busy_before_abort", busy, 1);
    rst = 1'b1;
    #1;
    chk("async_rst_outputs", {busy, valid, timeout, mismatch, period}, 0);
    @(negedge iclk);
    rst = 1'b0;
    run_meas(6, 6, 0, 1'b0, 1'b0);

    chk("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
